// File: rtl/mdu_pkg.sv
// Shared types and op decode helpers for the M-extension multiply/divide sequencer.
package mdu_pkg;

  localparam int MDU_XLEN  = 64;
  localparam int MDU_CNT_W = $clog2(MDU_XLEN);

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_DIVW, ALU_DIVUW,
    ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW
  } alufunc_t;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} mdu_state_t;

  function automatic logic is_muldiv(alufunc_t op);
    return op inside {ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_DIVW, ALU_DIVUW,
                      ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic is_mul_op(alufunc_t op);
    return op inside {ALU_MUL, ALU_MULW};
  endfunction

  function automatic logic is_w_op(alufunc_t op);
    return op inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic is_uns_op(alufunc_t op);
    return op inside {ALU_DIVU, ALU_DIVUW, ALU_REMU, ALU_REMUW};
  endfunction

  function automatic logic is_rem_op(alufunc_t op);
    return op inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module mdu_iter_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_n,
  output logic [XLEN-1:0] opa_n,
  output logic [XLEN-1:0] opb_n
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            ge;

  always_comb begin
    acc_n   = acc;
    opa_n   = opa;
    opb_n   = opb;
    // Partial remainder needs one extra bit: it can reach 2*divisor-1 before subtracting.
    rem_sh  = {acc, opb[XLEN-1]};
    rem_sub = rem_sh[XLEN-1:0] - opa;
    ge      = (rem_sh >= {1'b0, opa});
    if (is_div) begin
      acc_n = ge ? rem_sub : rem_sh[XLEN-1:0];
      opb_n = {opb[XLEN-2:0], ge};
    end else begin
      acc_n = acc + (opb[0] ? opa : '0);
      opa_n = opa << 1;
      opb_n = opb >> 1;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle mul/div/rem sequencer: operand prep, XLEN iterations, sign fix-up, held result.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  alufunc_t        req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return {{(XLEN-32){1'b0}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  mdu_state_t      state_q, state_d;
  alufunc_t        op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic [XLEN-1:0] step_acc, step_opa, step_opb;

  logic                   req_w, req_uns, req_rem, req_mul, signed_div, s1, s2;
  logic                   div_zero, ovf;
  logic signed [XLEN-1:0] ext1, ext2, min_val;
  logic [XLEN-1:0]        mag1, mag2, fast_res, fix_raw, fix_res;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .is_div (state_q == DIV),
    .acc    (acc_q),
    .opa    (opa_q),
    .opb    (opb_q),
    .acc_n  (step_acc),
    .opa_n  (step_opa),
    .opb_n  (step_opb)
  );

  // Operand preparation and fast-path detection on the offered request.
  always_comb begin
    req_w      = is_w_op(req_op);
    req_uns    = is_uns_op(req_op);
    req_rem    = is_rem_op(req_op);
    req_mul    = is_mul_op(req_op);
    signed_div = !req_mul && !req_uns;
    ext1       = req_w ? (req_uns ? zext32(req_src1) : sext32(req_src1)) : req_src1;
    ext2       = req_w ? (req_uns ? zext32(req_src2) : sext32(req_src2)) : req_src2;
    s1         = signed_div && ext1[XLEN-1];
    s2         = signed_div && ext2[XLEN-1];
    mag1       = s1 ? -ext1 : ext1;
    mag2       = s2 ? -ext2 : ext2;
    min_val    = req_w ? sext32({{(XLEN-32){1'b0}}, 32'h8000_0000}) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero   = (ext2 == '0);
    ovf        = signed_div && (ext1 == min_val) && (ext2 == '1);
    fast_res   = '0;
    if (div_zero)
      fast_res = req_rem ? (req_w ? sext32(req_src1) : req_src1) : '1;
    else if (ovf)
      fast_res = req_rem ? '0 : min_val;
  end

  // Final sign fix-up and result selection for the iterated op.
  always_comb begin
    if (is_mul_op(op_q))      fix_raw = acc_q;
    else if (is_rem_op(op_q)) fix_raw = neg_if(acc_q, neg_rem_q);
    else                      fix_raw = neg_if(opb_q, neg_quo_q);
    fix_res = is_w_op(op_q) ? sext32(fix_raw) : fix_raw;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid && is_muldiv(req_op)) begin
          op_d      = req_op;
          cnt_d     = CNT_W'(XLEN - 1);
          acc_d     = '0;
          neg_quo_d = s1 ^ s2;
          neg_rem_d = s1;
          if (req_mul) begin
            opa_d   = ext1;
            opb_d   = ext2;
            state_d = MUL;
          end else if (div_zero || ovf) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            opa_d   = mag2;
            opb_d   = mag1;
            state_d = DIV;
          end
        end
      end
      MUL, DIV: begin
        acc_d = step_acc;
        opa_d = step_opa;
        opb_d = step_opb;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    acc_q     <= acc_d;
    opa_q     <= opa_d;
    opb_q     <= opb_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: arithmetic reference model with per-cycle compare, plus literal vectors.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b0;
  alufunc_t    req_op = ALU_ADD;
  logic [63:0] req_src1 = '0;
  logic [63:0] req_src2 = '0;
  logic        req_ready, resp_valid, busy;
  logic [63:0] resp_result;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.XLEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit is_m(input alufunc_t op);
    return op inside {ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_DIVW, ALU_DIVUW,
                      ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

  // Reference result straight from the RISC-V M-extension rules.
  task automatic model(input alufunc_t op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output bit fast);
    longint      sa, sb;
    int          x, y;
    logic [31:0] t;
    logic [63:0] min64;
    sa = a; sb = b; x = a[31:0]; y = b[31:0];
    min64 = 64'h8000_0000_0000_0000;
    fast = 0; r = '0;
    case (op)
      ALU_MUL:  r = a * b;
      ALU_MULW: begin t = a[31:0] * b[31:0]; r = sx(t); end
      ALU_DIV: begin
        if (b == 0) begin r = '1; fast = 1; end
        else if (a == min64 && b == '1) begin r = min64; fast = 1; end
        else r = sa / sb;
      end
      ALU_DIVU: begin
        if (b == 0) begin r = '1; fast = 1; end
        else r = a / b;
      end
      ALU_REM: begin
        if (b == 0) begin r = a; fast = 1; end
        else if (a == min64 && b == '1) begin r = '0; fast = 1; end
        else r = sa % sb;
      end
      ALU_REMU: begin
        if (b == 0) begin r = a; fast = 1; end
        else r = a % b;
      end
      ALU_DIVW: begin
        if (y == 0) begin r = '1; fast = 1; end
        else if (x == 32'h8000_0000 && y == -1) begin r = sx(32'h8000_0000); fast = 1; end
        else begin t = x / y; r = sx(t); end
      end
      ALU_DIVUW: begin
        if (y == 0) begin r = '1; fast = 1; end
        else begin t = a[31:0] / b[31:0]; r = sx(t); end
      end
      ALU_REMW: begin
        if (y == 0) begin r = sx(a[31:0]); fast = 1; end
        else if (x == 32'h8000_0000 && y == -1) begin r = '0; fast = 1; end
        else begin t = x % y; r = sx(t); end
      end
      ALU_REMUW: begin
        if (y == 0) begin r = sx(a[31:0]); fast = 1; end
        else begin t = a[31:0] % b[31:0]; r = sx(t); end
      end
      default: r = '0;
    endcase
  endtask

  bit          m_started = 0, m_active = 0, m_done = 0;
  int          m_left = 0;
  logic [63:0] m_pend = '0, m_res = '0;

  // Transaction-level expectation: busy from accept until consumed, result after 66 or 1 cycles.
  always @(posedge clk) begin
    logic [63:0] r;
    bit          fast;
    m_started = 1;
    if (reset) begin
      m_active = 0; m_done = 0; m_res = '0;
    end else if (flush) begin
      m_active = 0; m_done = 0;
    end else if (m_done) begin
      if (resp_ready) m_done = 0;
    end else if (m_active) begin
      m_left--;
      if (m_left == 0) begin m_active = 0; m_done = 1; m_res = m_pend; end
    end else if (req_valid && is_m(req_op)) begin
      model(req_op, req_src1, req_src2, r, fast);
      if (fast) begin m_done = 1; m_res = r; end
      else begin m_active = 1; m_left = 65; m_pend = r; end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("cyc_busy", busy, m_active || m_done);
      check("cyc_req_ready", req_ready, !(m_active || m_done));
      check("cyc_resp_valid", resp_valid, m_done);
      if (m_done) check("cyc_resp_result", resp_result, m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input alufunc_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        input int stall);
    int n;
    bit got;
    req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
    tick();
    req_valid = 0; req_op = ALU_ADD; req_src1 = ~a; req_src2 = a ^ b;
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (resp_valid) got = 1;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_result"}, resp_result, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, resp_valid, 1'b1);
      check({name, "_hold_result"}, resp_result, exp);
      check({name, "_hold_req_ready"}, req_ready, 1'b0);
    end
    resp_ready = 1;
    tick();
    resp_ready = 0;
  endtask

  alufunc_t mops[10] = '{ALU_MUL, ALU_MULW, ALU_DIV, ALU_DIVU, ALU_DIVW, ALU_DIVUW,
                         ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};

  initial begin
    logic [63:0] a, b, r;
    bit          fast;
    alufunc_t    op;

    repeat (2) tick();
    @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_result", resp_result, 64'h0);
    reset = 0;
    tick();

    run_op("mul_7_m3", ALU_MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66, 5);
    run_op("divw_ovf", ALU_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remu_by0", ALU_REMU, 64'd100, 64'd0, 64'd100, 1, 0);
    run_op("divu_by0", ALU_DIVU, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_m7_2", ALU_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("div_m7_2", ALU_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op("mulw_wrap", ALU_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("div_ovf", ALU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", ALU_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0);
    run_op("remw_by0", ALU_REMW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_9ABC_DEF0, 1, 0);
    run_op("remw_m7_2", ALU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("divuw_max", ALU_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("mul_m1_m1", ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, 0);
    run_op("divu_big", ALU_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66, 0);

    // Flush mid-divide, then a fresh divide must run cleanly.
    req_valid = 1; req_op = ALU_DIV; req_src1 = 64'd1000; req_src2 = 64'd7;
    tick();
    req_valid = 0;
    repeat (29) tick();
    flush = 1;
    tick();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_busy", busy, 1'b0);
      check("flush_resp_valid", resp_valid, 1'b0);
    end
    tick();
    run_op("divu_10_3", ALU_DIVU, 64'd10, 64'd3, 64'd3, 66, 0);

    // Flush blocks a same-cycle request; non-M ops are ignored.
    flush = 1; req_valid = 1; req_op = ALU_DIV; req_src1 = 64'd9; req_src2 = 64'd3;
    tick();
    flush = 0; req_valid = 0;
    @(negedge clk);
    check("flush_req_busy", busy, 1'b0);
    req_valid = 1; req_op = ALU_ADD;
    tick();
    req_valid = 0;
    @(negedge clk);
    check("non_m_busy", busy, 1'b0);

    // Flush wins over resp_ready while a result is pending.
    req_valid = 1; req_op = ALU_DIVU; req_src1 = 64'd5; req_src2 = 64'd0;
    tick();
    req_valid = 0;
    @(negedge clk);
    check("pre_flush_valid", resp_valid, 1'b1);
    flush = 1; resp_ready = 1;
    tick();
    flush = 0; resp_ready = 0;
    @(negedge clk);
    check("flush_done_valid", resp_valid, 1'b0);

    // Reset in the middle of a multiply.
    tick();
    req_valid = 1; req_op = ALU_MUL; req_src1 = 64'd11; req_src2 = 64'd13;
    tick();
    req_valid = 0;
    repeat (10) tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_req_ready", req_ready, 1'b1);
    check("midreset_result", resp_result, 64'h0);
    tick();

    for (int i = 0; i < 8; i++) begin
      op = mops[$urandom_range(0, 9)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom} >> $urandom_range(0, 63);
      model(op, a, b, r, fast);
      run_op("rand", op, a, b, r, fast ? 1 : 66, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

endmodule
